// File: rtl/agc_instr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : agc_instr_decode
//  Description : AGC instruction decode stage. Absorbs the EXTEND prefix
//                into an extracode flag, applies a pending INDEX addend with
//                ones' complement arithmetic, classifies the effective word
//                and holds it for the control unit behind valid/ready.
//  Ports       : clk, reset_n (sync, active-low), flush
//                in_valid/in_ready/instr_word   - raw word from memory
//                idx_valid/idx_value            - INDEX operand strobe
//                out_valid/out_ready            - decoded handshake
//                opcode, qc, addr12, addr10, extracode, instr_id, eff_word
//                issue_count (only with AGC_DECODE_STATS_EN defined)
//  Options     : AGC_DECODE_STATS_EN adds a 16-bit handshake counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module agc_instr_decode #(
    parameter int                WORD_W      = 15,
    parameter logic [WORD_W-1:0] EXTEND_WORD = 15'o00006
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] instr_word,
    input  logic              idx_valid,
    input  logic [WORD_W-1:0] idx_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        opcode,
    output logic [1:0]        qc,
    output logic [11:0]       addr12,
    output logic [9:0]        addr10,
    output logic              extracode,
    output logic [4:0]        instr_id,
    output logic [WORD_W-1:0] eff_word
`ifdef AGC_DECODE_STATS_EN
    ,
    output logic [15:0]       issue_count
`endif
);

    localparam logic [4:0] c_ID_INDEX  = 5'd12;
    localparam logic [4:0] c_ID_INDEXX = 5'd27;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OUT  = 2'd1,
        S_IDXW = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] eff_q, eff_d;
    logic [4:0]        id_q, id_d;
    logic              extracode_q, extracode_d;
    logic              ext_pending_q, ext_pending_d;
    logic              idx_pending_q, idx_pending_d;
    logic [WORD_W-1:0] idx_reg_q, idx_reg_d;

    logic [WORD_W:0]   w_sum_raw;
    logic [WORD_W-1:0] w_eff_in;

    // Instruction class from the effective word and the extracode flag.
    function automatic logic [4:0] decode_id(input logic [WORD_W-1:0] w,
                                             input logic ext);
        logic [2:0]  op;
        logic [1:0]  q;
        logic [11:0] a;
        logic [4:0]  id;
        op = w[14:12];
        q  = w[11:10];
        a  = w[11:0];
        id = 5'd0;
        if (!ext) begin
            case (op)
                3'd0: begin
                    if (a == 12'd3)      id = 5'd1;
                    else if (a == 12'd4) id = 5'd2;
                    else if (a == 12'd6) id = 5'd3;
                    else                 id = 5'd0;
                end
                3'd1:    id = (q == 2'd0) ? 5'd4 : 5'd5;
                3'd2:    id = 5'd6 + {3'd0, q};
                3'd3:    id = 5'd10;
                3'd4:    id = 5'd11;
                3'd5:    id = 5'd12 + {3'd0, q};
                3'd6:    id = 5'd16;
                default: id = 5'd17;
            endcase
        end else begin
            case (op)
                3'd0:    id = 5'd18;
                3'd1:    id = (q == 2'd0) ? 5'd19 : 5'd20;
                3'd2:    id = 5'd21 + {3'd0, q};
                3'd3:    id = 5'd25;
                3'd4:    id = 5'd26;
                3'd5:    id = 5'd27;
                3'd6:    id = (q == 2'd0) ? 5'd28 : 5'd29;
                default: id = 5'd30;
            endcase
        end
        return id;
    endfunction

    // Ones' complement add with end-around carry. The carry re-add cannot
    // overflow again: the largest raw sum 77777+77777 leaves 77776 + 1.
    always_comb begin
        w_sum_raw = {1'b0, instr_word} + {1'b0, idx_reg_q};
        w_eff_in  = instr_word;
        if (idx_pending_q) begin
            w_eff_in = w_sum_raw[WORD_W-1:0] + {{(WORD_W-1){1'b0}}, w_sum_raw[WORD_W]};
        end
    end

    always_comb begin
        state_d       = state_q;
        eff_d         = eff_q;
        id_d          = id_q;
        extracode_d   = extracode_q;
        ext_pending_d = ext_pending_q;
        idx_pending_d = idx_pending_q;
        idx_reg_d     = idx_reg_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // An indexed word is never a prefix, whatever its value.
                    if (!idx_pending_q && (instr_word == EXTEND_WORD)) begin
                        ext_pending_d = 1'b1;
                    end else begin
                        eff_d         = w_eff_in;
                        id_d          = decode_id(w_eff_in, ext_pending_q);
                        extracode_d   = ext_pending_q;
                        ext_pending_d = 1'b0;
                        idx_pending_d = 1'b0;
                        state_d       = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if ((id_q == c_ID_INDEX) || (id_q == c_ID_INDEXX)) begin
                        // extracode carries across INDEX to the indexed word
                        ext_pending_d = extracode_q;
                        state_d       = S_IDXW;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_IDXW: begin
                if (idx_valid) begin
                    idx_reg_d     = idx_value;
                    idx_pending_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d       = S_IDLE;
            ext_pending_d = 1'b0;
            idx_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            eff_q         <= '0;
            id_q          <= '0;
            extracode_q   <= 1'b0;
            ext_pending_q <= 1'b0;
            idx_pending_q <= 1'b0;
            idx_reg_q     <= '0;
        end else begin
            state_q       <= state_d;
            eff_q         <= eff_d;
            id_q          <= id_d;
            extracode_q   <= extracode_d;
            ext_pending_q <= ext_pending_d;
            idx_pending_q <= idx_pending_d;
            idx_reg_q     <= idx_reg_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign eff_word  = eff_q;
    assign opcode    = eff_q[14:12];
    assign qc        = eff_q[11:10];
    assign addr12    = eff_q[11:0];
    assign addr10    = eff_q[9:0];
    assign extracode = extracode_q;
    assign instr_id  = id_q;

`ifdef AGC_DECODE_STATS_EN
    logic [15:0] issue_count_q, issue_count_d;

    // Counts handshakes only; flush does not clear it.
    always_comb begin
        issue_count_d = issue_count_q;
        if (out_valid && out_ready) begin
            issue_count_d = issue_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            issue_count_q <= '0;
        end else begin
            issue_count_q <= issue_count_d;
        end
    end

    assign issue_count = issue_count_q;
`endif

endmodule
`default_nettype wire
